// File: rtl/seg_display.sv
// Two-digit multiplexed seven-segment driver.
// Digit 0 shows the upstream value and digit 1 shows the selected operand
// index. The value digit's decimal point flashes for FLASH cycles after the
// value changes.
module seg_display #(
  parameter int unsigned REFRESH = 50_000,
  parameter int unsigned FLASH   = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data_in,
  input  logic       select,
  input  logic       en,
  output logic [6:0] seg_n,
  output logic [1:0] an_n,
  output logic       dp_n
);

  localparam int unsigned RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam int unsigned FW = $clog2(FLASH + 1);

  localparam logic [RW-1:0] RCNT_LAST = RW'(REFRESH - 1);
  localparam logic [FW-1:0] FCNT_LOAD = FW'(FLASH);

  typedef enum logic {
    DIG_VAL = 1'b0,
    DIG_SEL = 1'b1
  } digit_t;

  digit_t        idx, idx_nxt;
  logic [RW-1:0] rcnt, rcnt_nxt;
  logic          wrap;
  logic [FW-1:0] fcnt, fcnt_nxt;
  logic          change;
  logic [3:0]    val_reg;
  logic          sel_reg;
  logic [3:0]    digit;
  logic [6:0]    seg_nxt;
  logic [1:0]    an_nxt;
  logic          dp_nxt;

  // Active-low pattern for one digit; 10..15 render as a dash.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // Refresh counter: counts 0..REFRESH-1, wrap marks the end of a scan slot.
  always_comb begin
    wrap     = (rcnt == RCNT_LAST);
    rcnt_nxt = wrap ? '0 : rcnt + RW'(1);
  end

  // Digit scan FSM: advance to the other digit on every refresh wrap.
  always_comb begin
    idx_nxt = idx;
    case (idx)
      DIG_VAL: if (wrap) idx_nxt = DIG_SEL;
      DIG_SEL: if (wrap) idx_nxt = DIG_VAL;
      default: idx_nxt = DIG_VAL;
    endcase
  end

  // Flash counter: reload on any value change (retrigger), else count down to 0.
  always_comb begin
    change = (data_in != val_reg);
    if (change) begin
      fcnt_nxt = FCNT_LOAD;
    end else if (fcnt != '0) begin
      fcnt_nxt = fcnt - FW'(1);
    end else begin
      fcnt_nxt = fcnt;
    end
  end

  // Next output values, built from the current (registered) scan state.
  always_comb begin
    digit   = (idx == DIG_VAL) ? val_reg : {3'b000, sel_reg};
    seg_nxt = decode(digit);
    an_nxt  = '1;
    if (en) begin
      an_nxt = (idx == DIG_VAL) ? 2'b10 : 2'b01;
    end
    dp_nxt  = ~(en && (idx == DIG_VAL) && (fcnt != '0));
  end

  // Scan and flash state registers; rcnt and fcnt keep running while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= DIG_VAL;
      rcnt    <= '0;
      fcnt    <= '0;
      val_reg <= '0;
      sel_reg <= 1'b0;
    end else begin
      idx     <= idx_nxt;
      rcnt    <= rcnt_nxt;
      fcnt    <= fcnt_nxt;
      val_reg <= data_in;
      sel_reg <= select;
    end
  end

  // Registered outputs; blank while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n <= '1;
      an_n  <= '1;
      dp_n  <= 1'b1;
    end else begin
      seg_n <= seg_nxt;
      an_n  <= an_nxt;
      dp_n  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg_display.sv
// Bench for seg_display: three instances with different REFRESH/FLASH settings
// share the stimulus; expectations come from an edge-count model of the scan
// and flash behaviour.
module tb_seg_display;

  localparam int NI = 3;
  localparam int unsigned RR [NI] = '{4, 1000, 1};
  localparam int unsigned FF [NI] = '{10, 3, 1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] data_in = '0;
  logic       select = 1'b0;
  logic       en = 1'b0;

  logic [6:0] seg [NI];
  logic [1:0] an  [NI];
  logic       dp  [NI];

  seg_display #(.REFRESH(4), .FLASH(10)) u_a (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .select(select), .en(en),
    .seg_n(seg[0]), .an_n(an[0]), .dp_n(dp[0]));

  seg_display #(.REFRESH(1000), .FLASH(3)) u_b (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .select(select), .en(en),
    .seg_n(seg[1]), .an_n(an[1]), .dp_n(dp[1]));

  seg_display #(.REFRESH(1), .FLASH(1)) u_c (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .select(select), .en(en),
    .seg_n(seg[2]), .an_n(an[2]), .dp_n(dp[2]));

  always #5 clk = ~clk;

  logic [6:0] DEC [16];

  int vectors = 0;
  int miscompares = 0;

  // Model: k = edges since reset release; m_val/m_sel = inputs seen at the
  // previous edge; last_chg = edge at which data last differed from m_val.
  int         k;
  logic [3:0] m_val;
  logic       m_sel;
  int         last_chg;

  logic [6:0] e_seg [NI];
  logic [1:0] e_an  [NI];
  logic       e_dp  [NI];

  task automatic cmp(input string tag, input logic [6:0] got, input logic [6:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    k        = 0;
    m_val    = '0;
    m_sel    = 1'b0;
    last_chg = -1000000;
  endtask

  task automatic step(input logic [3:0] d, input logic s, input logic e);
    int  slot;
    int  age;
    logic show_sel;
    logic flashing;
    data_in = d;
    select  = s;
    en      = e;
    @(posedge clk);
    k++;
    for (int i = 0; i < NI; i++) begin
      slot     = (k - 1) / int'(RR[i]);
      show_sel = (slot % 2) == 1;
      age      = k - 1 - last_chg;
      flashing = age < int'(FF[i]);
      e_seg[i] = show_sel ? DEC[{3'b000, m_sel}] : DEC[m_val];
      e_an[i]  = !e ? 2'b11 : (show_sel ? 2'b01 : 2'b10);
      e_dp[i]  = !(e && !show_sel && flashing);
    end
    if (d != m_val) last_chg = k;
    m_val = d;
    m_sel = s;
    #1;
    for (int i = 0; i < NI; i++) begin
      cmp($sformatf("seg%0d_k%0d", i, k), seg[i], e_seg[i]);
      cmp($sformatf("an%0d_k%0d", i, k), {5'b0, an[i]}, {5'b0, e_an[i]});
      cmp($sformatf("dp%0d_k%0d", i, k), {6'b0, dp[i]}, {6'b0, e_dp[i]});
    end
  endtask

  // Assert reset between edges, check outputs before any edge, then release.
  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      cmp($sformatf("rst_seg%0d", i), seg[i], 7'h7F);
      cmp($sformatf("rst_an%0d", i), {5'b0, an[i]}, 7'h03);
      cmp($sformatf("rst_dp%0d", i), {6'b0, dp[i]}, 7'h01);
    end
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    DEC = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    model_reset();

    apply_reset();

    // Scan: value 3 on digit 0, select 1 on digit 1.
    for (int n = 0; n < 20; n++) step(4'd3, 1'b1, 1'b1);

    // Decode sweep right after reset so the slow-scan instance stays on digit 0.
    apply_reset();
    for (int v = 0; v < 16; v++) begin
      step(4'(v), 1'b0, 1'b1);
      step(4'(v), 1'b0, 1'b1);
    end

    // Flash: settle on 2, change to 7, retrigger with 9 five cycles later.
    for (int n = 0; n < 12; n++) step(4'd2, 1'b0, 1'b1);
    for (int n = 0; n < 5; n++)  step(4'd7, 1'b0, 1'b1);
    for (int n = 0; n < 20; n++) step(4'd9, 1'b0, 1'b1);

    // Enable low for 20 cycles with a change in the middle, then back on.
    for (int n = 0; n < 10; n++) step(4'd9, 1'b1, 1'b0);
    for (int n = 0; n < 10; n++) step(4'd4, 1'b1, 1'b0);
    for (int n = 0; n < 12; n++) step(4'd4, 1'b1, 1'b1);

    // Reset mid-flash and mid-scan.
    step(4'd6, 1'b0, 1'b1);
    step(4'd6, 1'b0, 1'b1);
    apply_reset();

    // Coincidence: change on the edge where the REFRESH=4 counter wraps.
    for (int n = 0; n < 3; n++)  step(4'd0, 1'b0, 1'b1);
    for (int n = 0; n < 16; n++) step(4'd5, 1'b1, 1'b1);

    // Random traffic with one reset in the middle.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] d;
      d = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : data_in;
      step(d, 1'($urandom), $urandom_range(0, 7) != 0);
      if (n == 200) apply_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
